// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: a Moore FSM that sequences lw/sw/R/I/beq/jal
// over a shared instruction/data memory, stretching memory states on MemReady.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       Trap,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;

    // NOTE: non-blocking assignment for the state register so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // NOTE: every output gets a default before the case, otherwise any state
    // that leaves one unassigned would infer a latch.
    always_comb begin
        next_state = FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        RegWrite   = 1'b0;
        InstrDone  = 1'b0;
        Trap       = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                next_state = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target OldPC+imm is parked in ALUOut here.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_BEQ:       next_state = BEQ;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                InstrDone  = MemReady;
                next_state = MemReady ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                PCWrite    = Zero;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                // PC <= ALUOut (target); OldPC+4 goes to rd in ALUWB.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            TRAP: begin
                Trap       = 1'b1;
                next_state = TRAP;
            end
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01:   ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite, InstrDone, Trap;
    logic [3:0] State;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .InstrDone(InstrDone),
        .Trap(Trap), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         passed = 0;
    logic       rst_val = 1'b1;
    logic [6:0] n_op = 7'd0;
    logic [2:0] n_f3 = 3'd0;
    logic       n_f7 = 1'b0;

    function automatic logic [21:0] actual();
        return {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegWrite, InstrDone, Trap};
    endfunction

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got state=%0d bits=%h, expected state=%0d bits=%h",
                      tag, got[21:18], got, want[21:18], want);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, actual(), e.v);
        end
    end

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        n_op = o; n_f3 = f3; n_f7 = f7;
    endtask

    // One clock cycle: drive inputs just after the edge, queue the outputs expected in it.
    task automatic cyc(input string tag, input logic z, input logic mr, input logic [3:0] st,
                       input logic pcw, input logic adr, input logic mw, input logic irw,
                       input logic [1:0] rs, input logic [1:0] asa, input logic [1:0] asb,
                       input logic [2:0] alu, input logic [1:0] imm,
                       input logic rw, input logic dn, input logic tr);
        exp_t e;
        @(posedge clk); #1;
        reset = rst_val; op = n_op; funct3 = n_f3; funct7b5 = n_f7;
        Zero = z; MemReady = mr;
        e.tag = tag;
        e.v   = {st, pcw, adr, mw, irw, rs, asa, asb, alu, imm, rw, dn, tr};
        exp_q.push_back(e);
    endtask

    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic is_imm, input logic [2:0] exp_alu);
        set_instr(o, f3, f7);
        cyc({tag, "_fetch"},  0, 1, 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0,0,0);
        cyc({tag, "_decode"}, 0, 1, 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b00, 0,0,0);
        if (is_imm)
            cyc({tag, "_exec"}, 0, 1, 4'd7, 0,0,0,0, 2'b00,2'b10,2'b01, exp_alu, 2'b00, 0,0,0);
        else
            cyc({tag, "_exec"}, 0, 1, 4'd6, 0,0,0,0, 2'b00,2'b10,2'b00, exp_alu, 2'b00, 0,0,0);
        cyc({tag, "_aluwb"},  0, 1, 4'd8, 0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 1,1,0);
    endtask

    initial begin
        // Reset held: FETCH selects, strobes low because MemReady is low.
        set_instr(7'd0, 3'd0, 1'b0);
        rst_val = 1'b1;
        cyc("reset0", 0, 0, 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0,0,0);
        cyc("reset1", 0, 0, 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0,0,0);
        rst_val = 1'b0;

        // R-type sub: 0,1,6,8
        run_alu("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001);

        // lw with two MEMREAD stalls: 7 cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fetch",  0, 1, 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0,0,0);
        cyc("lw_decode", 0, 1, 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b00, 0,0,0);
        cyc("lw_memadr", 0, 1, 4'd2, 0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 2'b00, 0,0,0);
        cyc("lw_rd_w0",  0, 0, 4'd3, 0,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0);
        cyc("lw_rd_w1",  0, 0, 4'd3, 0,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0);
        cyc("lw_rd_ok",  0, 1, 4'd3, 0,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0);
        cyc("lw_memwb",  0, 1, 4'd4, 0,0,0,0, 2'b01,2'b00,2'b00, 3'b000, 2'b00, 1,1,0);

        // sw with one MEMWRITE stall
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch",  0, 1, 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b01, 0,0,0);
        cyc("sw_decode", 0, 1, 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b01, 0,0,0);
        cyc("sw_memadr", 0, 1, 4'd2, 0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 2'b01, 0,0,0);
        cyc("sw_wr_w0",  0, 0, 4'd5, 0,1,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0,0,0);
        cyc("sw_wr_ok",  0, 1, 4'd5, 0,1,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0,1,0);

        // beq taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc("beq1_fetch",  1, 1, 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b10, 0,0,0);
        cyc("beq1_decode", 1, 1, 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b10, 0,0,0);
        cyc("beq1_beq",    1, 1, 4'd9, 1,0,0,0, 2'b00,2'b10,2'b00, 3'b001, 2'b10, 0,1,0);
        // beq not taken, with one FETCH stall first
        cyc("beq0_fstall", 0, 0, 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b10, 0,0,0);
        cyc("beq0_fetch",  0, 1, 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b10, 0,0,0);
        cyc("beq0_decode", 0, 1, 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b10, 0,0,0);
        cyc("beq0_beq",    0, 1, 4'd9, 0,0,0,0, 2'b00,2'b10,2'b00, 3'b001, 2'b10, 0,1,0);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch",  0, 1, 4'd0,  1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b11, 0,0,0);
        cyc("jal_decode", 0, 1, 4'd1,  0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b11, 0,0,0);
        cyc("jal_jal",    0, 1, 4'd10, 1,0,0,0, 2'b00,2'b01,2'b10, 3'b000, 2'b11, 0,0,0);
        cyc("jal_aluwb",  0, 1, 4'd8,  0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b11, 1,1,0);

        // ALU decode variety
        run_alu("r_or",    7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011);
        run_alu("r_slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101);
        run_alu("r_f3001", 7'b0110011, 3'b001, 1'b0, 1'b0, 3'b000);
        run_alu("r_add",   7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000);
        run_alu("i_and",   7'b0010011, 3'b111, 1'b0, 1'b1, 3'b010);
        run_alu("i_addf7", 7'b0010011, 3'b000, 1'b1, 1'b1, 3'b000);

        // Illegal opcode traps and holds with inputs that would otherwise strobe
        set_instr(7'b1110011, 3'b000, 1'b0);
        cyc("trp_fetch",  0, 1, 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0,0,0);
        cyc("trp_decode", 0, 1, 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b00, 0,0,0);
        for (int i = 0; i < 20; i++)
            cyc("trp_hold", 1, 1, 4'd11, 0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,1);
        // Reset mid-TRAP takes effect before the next edge
        rst_val = 1'b1;
        cyc("trp_reset", 1, 0, 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0,0,0);
        rst_val = 1'b0;

        // Reset mid-MEMWRITE drops MemWrite immediately
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw2_fetch",  0, 1, 4'd0, 1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 2'b01, 0,0,0);
        cyc("sw2_decode", 0, 1, 4'd1, 0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 2'b01, 0,0,0);
        cyc("sw2_memadr", 0, 1, 4'd2, 0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 2'b01, 0,0,0);
        cyc("sw2_wr_w0",  0, 0, 4'd5, 0,1,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0,0,0);
        rst_val = 1'b1;
        cyc("sw2_reset",  0, 0, 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b01, 0,0,0);
        cyc("sw2_reset2", 0, 0, 4'd0, 0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b01, 0,0,0);
        rst_val = 1'b0;

        // Recovery after reset
        run_alu("r_after", 7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001);

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal). It replaces the single-cycle controller when the datapath is rebuilt around a shared instruction/data memory with the architectural registers IR, OldPC, A, WriteData, Data and ALUOut. A Moore FSM sequences one instruction over 3–5 cycles and stretches its memory states on a ready handshake. Unimplemented opcodes are trapped rather than driven with X.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the access presented this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- InstrDone  out  1  high in the last cycle of every retired instruction
- Trap  out  1  illegal opcode seen; sticky until reset
- State  out  4  current state encoding (debug)

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11. Codes 12–15 go to FETCH.
- Defaults in every state: all enables 0, all selects 00, ALUOp 00.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, add. IRWrite = PCWrite = MemReady. Next state is DECODE if MemReady, else FETCH.
- DECODE: ALUSrcA 01, ALUSrcB 01, add (computes the branch target into ALUOut). Next state by op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → TRAP
- MEMADR: ALUSrcA 10, ALUSrcB 01, add. Next state is MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: AdrSrc 1, ResultSrc 00. Waits for MemReady, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1, InstrDone 1. Next state FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite held at 1 while waiting. When MemReady: InstrDone 1, next state FETCH.
- EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10. EXECUTEI: the same but ALUSrcB 01. Both go to ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1, InstrDone 1. Next state FETCH.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01 (sub), ResultSrc 00. PCWrite = Zero, InstrDone 1. Next state FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1. Next state ALUWB, which writes OldPC+4 to rd.
- TRAP: all enables 0, Trap 1. Stays in TRAP until reset.
- ALU decode:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10 decodes funct3: 000 gives sub if funct7b5 & op[5], else add; 010 → slt; 110 → or; 111 → and; any other funct3 → add (never X).
- ImmSrc is combinational from op in every state: sw 01, beq 10, jal 11, otherwise 00.

## Timing
- Reset: State = 0 asynchronously. All enables 0 except the MemReady-gated FETCH strobes; Trap 0, InstrDone 0.
- First FETCH with MemReady = 1 occurs in the first rising edge after reset deasserts.
- Cycles per instruction with MemReady held at 1: lw 5, sw 4, R 4, I 4, jal 4, beq 3. Each cycle of MemReady = 0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Outputs depend only on State, plus MemReady (FETCH strobes, MEMWRITE InstrDone), Zero (BEQ), and op/funct for ALUControl and ImmSrc. No output depends combinationally on reset release.
- Reset asserted mid-instruction aborts it with no further enable pulses. A MemWrite in flight drops in the same cycle reset rises.
- MemWrite is never high outside MEMWRITE. RegWrite is never high outside MEMWB/ALUWB. PCWrite is never high outside FETCH, BEQ and JAL.

## Test plan
- Reset, then MemReady = 1 with op = 0110011, funct3 = 000, funct7b5 = 1 → State 0,1,6,8,0. ALUControl is 001 in EXECUTER. RegWrite and InstrDone are 1 only in cycle 4.
- lw (op = 0000011) with MemReady = 0 for 2 cycles in MEMREAD → 7 cycles total. MEMWB has ResultSrc 01 and RegWrite 1. IRWrite pulses exactly once.
- sw (op = 0100011) with MemReady low for 1 cycle in MEMWRITE → MemWrite stays high for 2 consecutive cycles with AdrSrc 1 and ImmSrc 01. InstrDone rises on the second of those cycles.
- beq (op = 1100011) with Zero = 1, then with Zero = 0 → both take 3 cycles. PCWrite is 1 in BEQ only when Zero = 1. ALUControl is 001.
- jal (op = 1101111) → JAL has PCWrite 1 and ImmSrc 11. ALUWB follows with RegWrite 1. 4 cycles total.
- Illegal op 7'b1110011 → State 11 and Trap 1, held for 20 cycles with no enable pulses. Asserting reset mid-TRAP (and separately mid-MEMWRITE) → State 0 immediately, Trap 0, MemWrite 0.
